step_clock_gen: RTL and testbench

//  Turns a raw, bouncing push-button into a clean processor clock and step strobe.

---
 rtl/step_clock_gen.sv | 92 +++++++++
 tb/tb_step_clock_gen.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/step_clock_gen.sv
// step_clock_gen: debounced push-button or free-running divider turned into a clean
// processor clock level, a one-cycle step strobe and a wrapping step counter.
module step_clock_gen #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int RUN_DIV         = 25000000,
    parameter int CNT_W           = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             KeyN,
    input  logic             RunMode,
    output logic             ProcClk,
    output logic             Step,
    output logic             KeyLevel,
    output logic [CNT_W-1:0] StepCount
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int VW = $clog2(RUN_DIV);
    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [VW-1:0] DIV_LAST = VW'(RUN_DIV - 1);
    localparam logic [VW-1:0] DIV_HALF = VW'(RUN_DIV / 2);

    typedef enum logic [1:0] {IDLE, DB_PRESS, PRESSED, DB_REL} state_t;

    state_t        r_state;
    logic [DW-1:0] r_db_cnt;
    logic [VW-1:0] r_div;
    logic [1:0]    r_kn_sync;
    logic [1:0]    r_rm_sync;
    logic          r_rm_d;

    logic          w_kn_s;
    logic          w_rm_s;
    logic          w_chg;
    logic          w_db_done;
    logic          w_press_done;
    logic          w_key_n;
    logic          w_step_n;
    logic          w_proc_n;
    logic [VW-1:0] w_div_n;

    assign w_kn_s       = r_kn_sync[1];
    assign w_rm_s       = r_rm_sync[1];
    assign w_chg        = w_rm_s != r_rm_d;
    assign w_db_done    = r_db_cnt == DB_LAST;
    assign w_press_done = r_state == DB_PRESS && !w_kn_s && w_db_done;
    // Outputs are registered from the next debounce state so Step, KeyLevel and ProcClk rise together.
    assign w_key_n      = r_state == PRESSED || (r_state == DB_REL && !(w_kn_s && w_db_done)) || w_press_done;
    assign w_step_n     = !w_chg && (w_rm_s ? r_div == '0 : w_press_done);
    assign w_proc_n     = !w_chg && (w_rm_s ? r_div < DIV_HALF : w_key_n);
    assign w_div_n      = (w_chg || !w_rm_s || r_div == DIV_LAST) ? '0 : r_div + VW'(1);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_kn_sync <= 2'b11;
            r_rm_sync <= 2'b00;
            r_rm_d    <= 1'b0;
            r_state   <= IDLE;
            r_db_cnt  <= '0;
            r_div     <= '0;
            KeyLevel  <= 1'b0;
            ProcClk   <= 1'b0;
            Step      <= 1'b0;
            StepCount <= '0;
        end else begin
            r_kn_sync <= {r_kn_sync[0], KeyN};
            r_rm_sync <= {r_rm_sync[0], RunMode};
            r_rm_d    <= w_rm_s;
            case (r_state)
                IDLE: if (!w_kn_s) begin
                    r_state  <= DB_PRESS;
                    r_db_cnt <= '0;
                end
                DB_PRESS: if (w_kn_s) r_state <= IDLE;
                    else if (w_db_done) r_state <= PRESSED;
                    else r_db_cnt <= r_db_cnt + DW'(1);
                PRESSED: if (w_kn_s) begin
                    r_state  <= DB_REL;
                    r_db_cnt <= '0;
                end
                DB_REL: if (!w_kn_s) r_state <= PRESSED;
                    else if (w_db_done) r_state <= IDLE;
                    else r_db_cnt <= r_db_cnt + DW'(1);
            endcase
            KeyLevel  <= w_key_n;
            ProcClk   <= w_proc_n;
            Step      <= w_step_n;
            StepCount <= StepCount + CNT_W'(w_step_n);
            r_div     <= w_div_n;
        end
    end
endmodule

// File: tb/tb_step_clock_gen.sv
// tb_step_clock_gen: randomized and directed stimulus against a run-length reference model;
// expected step events go through a queue that a negedge monitor drains.
module tb_step_clock_gen;
    localparam int D  = 4;
    localparam int RD = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          key_n = 1'b1;
    logic          run_mode = 1'b0;
    logic          proc_clk;
    logic          step;
    logic          key_level;
    logic [CW-1:0] step_count;

    step_clock_gen #(.DEBOUNCE_CYCLES(D), .RUN_DIV(RD), .CNT_W(CW)) dut (
        .Clk(clk), .Reset(rst), .KeyN(key_n), .RunMode(run_mode),
        .ProcClk(proc_clk), .Step(step), .KeyLevel(key_level), .StepCount(step_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a level is accepted after D+1 consecutive opposing samples,
    // with inputs seen two edges late; run mode steps every RD edges after a mode change.
    int  edge_n = 0;
    int  t0 = 0;
    int  run_len = 0;
    int  m_cnt = 0;
    bit  lvl = 0;
    bit  kd0 = 1, kd1 = 1;
    bit  rd0 = 0, rd1 = 0, rd2 = 0;
    bit  exp_pc = 0, exp_kl = 0;
    int  step_q[$];

    task automatic model_edge();
        bit pressed, rose, chg, st;
        int k;
        if (rst) begin
            lvl = 0; run_len = 0; m_cnt = 0;
            kd0 = 1; kd1 = 1; rd0 = 0; rd1 = 0; rd2 = 0;
            exp_pc = 0; exp_kl = 0;
            step_q.delete();
            return;
        end
        edge_n++;
        pressed = !kd1;
        rose = 0;
        st = 0;
        if (pressed != lvl) begin
            run_len++;
            if (run_len == D + 1) begin
                lvl = pressed;
                run_len = 0;
                rose = lvl;
            end
        end else run_len = 0;
        chg = rd1 != rd2;
        if (chg) begin
            t0 = edge_n;
            exp_pc = 0;
        end else if (rd1) begin
            k = (edge_n - t0 - 1) % RD;
            st = k == 0;
            exp_pc = k < RD / 2;
        end else begin
            st = rose;
            exp_pc = lvl;
        end
        exp_kl = lvl;
        if (st) begin
            m_cnt = (m_cnt + 1) % (1 << CW);
            step_q.push_back(edge_n);
        end
        kd1 = kd0; kd0 = key_n;
        rd2 = rd1; rd1 = rd0; rd0 = run_mode;
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        model_edge();
    end

    initial forever begin
        @(negedge clk);
        if (rst) check("reset_outputs", {proc_clk, step, key_level, step_count}, 0);
        else begin
            check("proc_clk", proc_clk, exp_pc);
            check("key_level", key_level, exp_kl);
            check("step_count", step_count, m_cnt);
            if (step) begin
                if (step_q.size() == 0) check("spurious_step", 1, 0);
                else check("step_edge", edge_n, step_q.pop_front());
            end else if (step_q.size() != 0 && step_q[0] <= edge_n) begin
                check("missed_step", 0, 1);
                void'(step_q.pop_front());
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        cyc(3);
        rst = 0;
        // Clean press: accepted on the 7th edge after the first sample.
        cyc(1); key_n = 0;
        cyc(6);
        check("t1_level_before", key_level, 0);
        cyc(1);
        check("t1_step", step, 1);
        check("t1_level", key_level, 1);
        check("t1_count", step_count, 1);
        cyc(13); key_n = 1;
        cyc(6);
        check("t1_pc_before_rel", proc_clk, 1);
        cyc(1);
        check("t1_pc_rel", proc_clk, 0);
        cyc(5);
        check("t1_count_after", step_count, 1);
        // Short pulses are rejected.
        for (int w = 1; w <= 3; w++) begin
            key_n = 0; cyc(w);
            key_n = 1; cyc(2);
        end
        cyc(8);
        check("t2_level", key_level, 0);
        check("t2_count", step_count, 1);
        // Release glitch while held.
        key_n = 0; cyc(12);
        key_n = 1; cyc(2);
        key_n = 0; cyc(10);
        check("t3_count", step_count, 2);
        check("t3_pc", proc_clk, 1);
        key_n = 1; cyc(12);
        // Run mode from a fresh reset.
        rst = 1; cyc(1);
        rst = 0; cyc(1);
        run_mode = 1; cyc(40);
        check("t4_count5", step_count, 5);
        cyc(136);
        check("t4_wrap", step_count, 6);
        // Hold key in run mode, then drop back to manual during a high phase.
        key_n = 0; cyc(5);
        check("t5_pc_high", proc_clk, 1);
        run_mode = 0; cyc(12);
        check("t5_pc_follow", proc_clk, 1);
        check("t5_level", key_level, 1);
        key_n = 1; cyc(10);
        // Reset while pressed with three steps counted.
        rst = 1; cyc(1);
        rst = 0;
        for (int p = 0; p < 3; p++) begin
            key_n = 0; cyc(9);
            if (p < 2) begin key_n = 1; cyc(9); end
        end
        check("t6_count3", step_count, 3);
        rst = 1; #1;
        check("t6_rst_pc", proc_clk, 0);
        check("t6_rst_level", key_level, 0);
        check("t6_rst_count", step_count, 0);
        cyc(1);
        rst = 0;
        cyc(6);
        check("t6_count_before", step_count, 0);
        cyc(1);
        check("t6_step", step, 1);
        check("t6_count1", step_count, 1);
        key_n = 1; cyc(10);
        // Randomized bouncing key and mode switching.
        repeat (150) begin
            key_n = 1'($urandom_range(0, 1));
            cyc($urandom_range(1, 8));
            if ($urandom_range(0, 9) == 0) run_mode = !run_mode;
        end
        run_mode = 0; key_n = 1; cyc(20);
        check("queue_empty", step_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
